// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - one RAM read/write per request between MAR/MDR and a ready-handshake RAM port
module mem_access_unit #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [31:0]       mar,
    input  logic [31:0]       mdr,
    output logic [31:0]       MDataIn,
    output logic              MD_Read,
    output logic              mdr_load,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    // TIMEOUT=0 disables the abort, but the counter still needs at least one bit
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RLOAD,
        S_WRITE,
        S_WDONE,
        S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               fail_rd_q, fail_rd_d;
    logic               addr_oor;
    logic               timed_out;

    assign addr_oor  = |mar[31:ADDR_W];
    assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
            fail_rd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
            fail_rd_q  <= fail_rd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        fail_rd_d  = fail_rd_q;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (rd_req || wr_req) begin
                    addr_d    = mar[ADDR_W-1:0];
                    fail_rd_d = rd_req;
                    if (!rd_req) begin
                        wdata_d = mdr;
                    end
                    // a rejected read still loads the MDR, so it must see zero
                    if (addr_oor) begin
                        state_d = S_FAIL;
                        if (rd_req) begin
                            rdata_d = '0;
                        end
                    end else begin
                        state_d = rd_req ? S_READ : S_WRITE;
                    end
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    state_d = S_RLOAD;
                end else if (timed_out) begin
                    rdata_d = '0;
                    state_d = S_FAIL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    state_d = S_WDONE;
                end else if (timed_out) begin
                    state_d = S_FAIL;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RLOAD: state_d = S_IDLE;
            S_WDONE: state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_re    = (state_q == S_READ);
    assign mem_we    = (state_q == S_WRITE);
    assign done      = (state_q == S_RLOAD) || (state_q == S_WDONE) || (state_q == S_FAIL);
    assign err       = (state_q == S_FAIL);
    assign MD_Read   = (state_q == S_RLOAD) || ((state_q == S_FAIL) && fail_rd_q);
    assign mdr_load  = MD_Read;
    assign MDataIn   = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              clr = 1'b1;
    logic              rd_req = 1'b0;
    logic              wr_req = 1'b0;
    logic [31:0]       mar = '0;
    logic [31:0]       mdr = '0;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic [31:0]       MDataIn;
    logic              MD_Read, mdr_load, done, err, busy, mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    logic [31:0] ram [512];
    logic [31:0] last_mdata;
    int          n_tests = 0;
    int          n_fail = 0;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .clr(clr), .rd_req(rd_req), .wr_req(wr_req), .mar(mar), .mdr(mdr),
        .MDataIn(MDataIn), .MD_Read(MD_Read), .mdr_load(mdr_load), .done(done), .err(err),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // One transaction; the bench acts as the RAM, asserting ready after 'waits' wait cycles.
    // Expected timeline: strobe for S cycles, done in cycle S+1 (S=0 for out-of-range).
    task automatic run_txn(input string tag, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d, input int waits);
        bit                is_rd, oor, ok;
        int                s, dc;
        logic [ADDR_W-1:0] a9;
        logic [6:0]        exp_f;
        is_rd = rd;
        a9    = a[ADDR_W-1:0];
        oor   = (a >> ADDR_W) != 0;
        ok    = !oor && (waits <= TIMEOUT);
        s     = oor ? 0 : (ok ? waits + 1 : TIMEOUT + 1);
        dc    = s + 1;
        @(negedge clk);
        rd_req = rd; wr_req = wr; mar = a; mdr = d;
        mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        for (int k = 1; k <= dc + 1; k++) begin
            @(negedge clk);
            rd_req = 1'b0; wr_req = 1'b0; mar = $urandom; mdr = $urandom;
            if (k <= s) begin
                mem_ready = ok && (k - 1 == waits);
                mem_rdata = mem_ready ? ram[a9] : $urandom;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (k == dc && is_rd) last_mdata = ok ? ram[a9] : 32'h0;
            if (k == dc && !is_rd && ok) ram[a9] = d;
            exp_f = {k <= dc, (k <= s) && is_rd, (k <= s) && !is_rd, k == dc,
                     (k == dc) && !ok, (k == dc) && is_rd, (k == dc) && is_rd};
            n_tests++;
            if ({busy, mem_re, mem_we, done, err, MD_Read, mdr_load} !== exp_f) begin
                n_fail++;
                $display("FAIL %s cycle %0d flags busy/re/we/done/err/mdrd/load: got %b expected %b",
                         tag, k, {busy, mem_re, mem_we, done, err, MD_Read, mdr_load}, exp_f);
            end
            n_tests++;
            if (MDataIn !== last_mdata) begin
                n_fail++;
                $display("FAIL %s cycle %0d MDataIn: got %h expected %h", tag, k, MDataIn, last_mdata);
            end
            if (k <= s) begin
                n_tests++;
                if (mem_addr !== a9 || (!is_rd && mem_wdata !== d)) begin
                    n_fail++;
                    $display("FAIL %s cycle %0d addr/wdata: got %h/%h expected %h/%h",
                             tag, k, mem_addr, mem_wdata, a9, d);
                end
            end
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({MDataIn, mem_addr, mem_wdata, busy, mem_re, mem_we, done, err, MD_Read, mdr_load} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got md=%h addr=%h wd=%h flags=%b expected all zero",
                     MDataIn, mem_addr, mem_wdata, {busy, mem_re, mem_we, done, err, MD_Read, mdr_load});
        end
        clr = 1'b0;
        last_mdata = 32'h0;
    endtask

    task automatic test_read_immediate();
        ram[5] = 32'h1234_5678;
        run_txn("read_imm", 1'b1, 1'b0, 32'd5, 32'h0, 0);
    endtask

    task automatic test_write_waits();
        run_txn("write_3w", 1'b0, 1'b1, 32'd9, 32'hA5A5_0001, 3);
        run_txn("readback9", 1'b1, 1'b0, 32'd9, 32'h0, 0);
    endtask

    task automatic test_timeout();
        run_txn("rd_timeout", 1'b1, 1'b0, 32'd5, 32'h0, 100);
        run_txn("wr_timeout", 1'b0, 1'b1, 32'd12, 32'hDEAD_BEEF, 100);
    endtask

    task automatic test_both_req();
        run_txn("both_req", 1'b1, 1'b1, 32'd3, $urandom, 1);
    endtask

    task automatic test_out_of_range();
        run_txn("oor_read", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 0);
        run_txn("oor_write", 1'b0, 1'b1, 32'h8000_0001, 32'h1111_2222, 0);
        run_txn("top_addr", 1'b1, 1'b0, 32'h0000_01FF, 32'h0, 2);
    endtask

    task automatic test_clr_mid_read();
        @(negedge clk);
        rd_req = 1'b1; mar = 32'd7; mem_ready = 1'b0;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        n_tests++;
        if ({busy, mem_re, done, mdr_load} !== 4'b0000 || MDataIn !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_async busy/re/done/load: got %b md=%h expected 0000 md=0",
                     {busy, mem_re, done, mdr_load}, MDataIn);
        end
        @(negedge clk);
        clr = 1'b0;
        last_mdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++;
            if ({busy, mem_re, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL clr_after cycle %0d busy/re/done: got %b expected 000", k, {busy, mem_re, done});
            end
        end
        run_txn("read_after_clr", 1'b1, 1'b0, 32'd7, 32'h0, 1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_md;
        old_md = last_mdata;
        @(negedge clk);
        rd_req = 1'b1; mar = 32'd20; mem_ready = 1'b1; mem_rdata = ram[20];
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) rd_req = 1'b0;
            n_tests++;
            if (done !== (k == 2 || k == 5) || busy !== !(k == 3 || k == 6)) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d done/busy: got %b%b expected %b%b",
                         k, done, busy, (k == 2 || k == 5), !(k == 3 || k == 6));
            end
            n_tests++;
            if (MDataIn !== ((k < 2) ? old_md : ram[20])) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d MDataIn: got %h expected %h",
                         k, MDataIn, (k < 2) ? old_md : ram[20]);
            end
        end
        last_mdata = ram[20];
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          w;
        bit          r, wq;
        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
            w  = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT + 1, TIMEOUT + 2)
                                             : $urandom_range(0, TIMEOUT - 1);
            r  = 1'($urandom_range(0, 1));
            wq = r ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn("random", r, wq, a, $urandom, w);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = $urandom;
        last_mdata = 32'h0;
        test_reset();
        test_read_immediate();
        test_write_waits();
        test_timeout();
        test_both_req();
        test_out_of_range();
        test_clr_mid_read();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
